cu_multicycle: RTL and testbench

- Parametrised successor to the 8-bit control unit: a multicycle fetch/decode/execute FSM driving the datapath strobes (MAR, MBR, IR, PC, RF, Acc, RAM, ALU muxes).
- Generalised in data width and register count.
- Adds over the previous generation: two-word immediate/memory instructions, a memory-ready wait handshake, a compare flag strobe, a halt request, and a defined reset state.

---
 rtl/cu_pkg.sv | 90 +++++++++
 rtl/cu_decode.sv | 40 ++++
 rtl/cu_multicycle.sv | 207 ++++++++++++++++++++
 tb/tb_cu_multicycle.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the multicycle control unit.
// Optional build macro: CU_WAIT_EN (memory-ready wait handshake).
package cu_pkg;

  // FSM states; the numeric value is what appears on the state output
  typedef enum logic [4:0] {
    IDLE = 5'd0,
    F0   = 5'd1,
    F1   = 5'd2,
    F2   = 5'd3,
    DEC  = 5'd4,
    O0   = 5'd5,
    O1   = 5'd6,
    EXA  = 5'd7,
    EXI  = 5'd8,
    MR0  = 5'd9,
    MR1  = 5'd10,
    A0   = 5'd11,
    A1   = 5'd12,
    A2   = 5'd13,
    S1   = 5'd14,
    S2   = 5'd15,
    HALT = 5'd16
  } cu_state_e;

  // Instruction classes the decoder sorts opcodes into
  typedef enum logic [2:0] {
    CL_LD  = 3'd0,
    CL_ST  = 3'd1,
    CL_MR  = 3'd2,
    CL_MI  = 3'd3,
    CL_ALU = 3'd4,
    CL_CMP = 3'd5
  } cu_class_e;

  // Opcodes (cu_in[DW-1:DW-4])
  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_ST  = 4'b0001;
  localparam logic [3:0] OP_MI  = 4'b0010;
  localparam logic [3:0] OP_MR  = 4'b0011;
  localparam logic [3:0] OP_SUM = 4'b0100;
  localparam logic [3:0] OP_SB  = 4'b0101;
  localparam logic [3:0] OP_ANR = 4'b0110;
  localparam logic [3:0] OP_CM  = 4'b0111;
  localparam logic [3:0] OP_ORR = 4'b1000;
  localparam logic [3:0] OP_ORI = 4'b1001;
  localparam logic [3:0] OP_XRR = 4'b1010;
  localparam logic [3:0] OP_XRI = 4'b1011;
  localparam logic [3:0] OP_SMI = 4'b1100;
  localparam logic [3:0] OP_SBI = 4'b1101;
  localparam logic [3:0] OP_ANI = 4'b1110;
  localparam logic [3:0] OP_CMI = 4'b1111;

  // ALU modes
  localparam logic [2:0] MODE_SUM  = 3'b000;
  localparam logic [2:0] MODE_SB   = 3'b001;
  localparam logic [2:0] MODE_CM   = 3'b010;
  localparam logic [2:0] MODE_AND  = 3'b011;
  localparam logic [2:0] MODE_OR   = 3'b100;
  localparam logic [2:0] MODE_XOR  = 3'b101;
  localparam logic [2:0] MODE_PASS = 3'b110;

  // MAR source select
  localparam logic [1:0] RAM_IN_PC  = 2'b00;
  localparam logic [1:0] RAM_IN_MBR = 2'b01;

  // Single-bit datapath strobes and status, held together in one register
  typedef struct packed {
    logic mbr_we;
    logic ir_we;
    logic pc_inc;
    logic rf_we;
    logic acc_we;
    logic mar_we;
    logic ram_we;
    logic alu_mux;
    logic rf_mux;
    logic alu_out_mux;
    logic mbr_mux;
    logic data_imm;
    logic flag_we;
    logic halted;
  } cu_strb_t;

  // States that perform a RAM access and may stretch on mem_rdy
  function automatic logic is_mem_wait(input cu_state_e s);
    return (s == F1) || (s == O1) || (s == A1) || (s == S2);
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decoder: opcode -> {class, is_imm, ALU mode}.
// Shared by the DEC branch and the EXA output decode.
module cu_decode
  import cu_pkg::*;
#(
  parameter int MODE_W = 3
) (
  input  logic [3:0]        opcode,
  output cu_class_e         op_class,
  output logic              is_imm,
  output logic [MODE_W-1:0] mode
);

  // Map each opcode onto its class, operand source and ALU operation
  always_comb begin
    op_class = CL_ALU;
    is_imm   = 1'b0;
    mode     = MODE_W'(MODE_SUM);
    case (opcode)
      OP_LD:  begin op_class = CL_LD; is_imm = 1'b1; mode = MODE_W'(MODE_PASS); end
      OP_ST:  begin op_class = CL_ST; is_imm = 1'b1; end
      OP_MR:  begin op_class = CL_MR; end
      OP_MI:  begin op_class = CL_MI; is_imm = 1'b1; mode = MODE_W'(MODE_PASS); end
      OP_SUM: begin mode = MODE_W'(MODE_SUM); end
      OP_SMI: begin is_imm = 1'b1; mode = MODE_W'(MODE_SUM); end
      OP_SB:  begin mode = MODE_W'(MODE_SB); end
      OP_SBI: begin is_imm = 1'b1; mode = MODE_W'(MODE_SB); end
      OP_CM:  begin op_class = CL_CMP; mode = MODE_W'(MODE_CM); end
      OP_CMI: begin op_class = CL_CMP; is_imm = 1'b1; mode = MODE_W'(MODE_CM); end
      OP_ANR: begin mode = MODE_W'(MODE_AND); end
      OP_ANI: begin is_imm = 1'b1; mode = MODE_W'(MODE_AND); end
      OP_ORR: begin mode = MODE_W'(MODE_OR); end
      OP_ORI: begin is_imm = 1'b1; mode = MODE_W'(MODE_OR); end
      OP_XRR: begin mode = MODE_W'(MODE_XOR); end
      OP_XRI: begin is_imm = 1'b1; mode = MODE_W'(MODE_XOR); end
      default: begin op_class = CL_ALU; is_imm = 1'b0; mode = MODE_W'(MODE_SUM); end
    endcase
  end

endmodule

// File: rtl/cu_multicycle.sv
// Multicycle fetch/decode/execute control unit.
// Outputs are registered from the next state so each state's strobes
// appear exactly while that state is held. Define CU_WAIT_EN to let the
// RAM-access states stretch until mem_rdy; otherwise mem_rdy is ignored.
// Legal configurations satisfy 2*RSEL_W <= DW-4.
module cu_multicycle
  import cu_pkg::*;
#(
  parameter int DW     = 8,
  parameter int RSEL_W = 2,
  parameter int MODE_W = 3
) (
  input  logic              cu_clk,
  input  logic              cu_rst,
  input  logic [DW-1:0]     cu_in,
  input  logic              mem_rdy,
  input  logic              halt_req,
  output logic [4:0]        state,
  output logic [MODE_W-1:0] mode,
  output logic [RSEL_W-1:0] select,
  output logic [1:0]        ram_in,
  output logic              mbr_we,
  output logic              ir_we,
  output logic              pc_inc,
  output logic              rf_we,
  output logic              acc_we,
  output logic              mar_we,
  output logic              ram_we,
  output logic              alu_mux,
  output logic              rf_mux,
  output logic              alu_out_mux,
  output logic              mbr_mux,
  output logic              data_imm,
  output logic              flag_we,
  output logic              halted
);

  logic [RSEL_W-1:0] rs_s, rd_s;
  cu_class_e         op_class_s;
  logic              is_imm_s;
  logic [MODE_W-1:0] dec_mode_s;
  logic              adv_s;
  logic              gate_s;
  cu_state_e         end_s;
  cu_state_e         state_r, nxt_s;
  cu_strb_t          strb_r, strb_nxt_s;
  logic [MODE_W-1:0] mode_r, mode_nxt_s;
  logic [RSEL_W-1:0] select_r, select_nxt_s;
  logic [1:0]        ram_in_r, ram_in_nxt_s;

  assign rs_s = cu_in[RSEL_W-1:0];
  assign rd_s = cu_in[2*RSEL_W-1:RSEL_W];

  cu_decode #(.MODE_W(MODE_W)) u_decode (
    .opcode   (cu_in[DW-1:DW-4]),
    .op_class (op_class_s),
    .is_imm   (is_imm_s),
    .mode     (dec_mode_s)
  );

`ifdef CU_WAIT_EN
  // Memory states advance, and their strobes fire, only once RAM is ready
  assign adv_s  = mem_rdy;
  assign gate_s = mem_rdy | ~is_mem_wait(state_r);
`else
  logic unused_mem_rdy_s;
  assign adv_s            = 1'b1;
  assign gate_s           = 1'b1;
  assign unused_mem_rdy_s = mem_rdy;
`endif

  assign end_s = halt_req ? HALT : F0;

  // Next-state selection, including the instruction-boundary halt check
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      IDLE: nxt_s = F0;
      F0:   nxt_s = F1;
      F1:   nxt_s = adv_s ? F2 : F1;
      F2:   nxt_s = DEC;
      DEC: begin
        case (op_class_s)
          CL_MR:          nxt_s = MR0;
          CL_ALU, CL_CMP: nxt_s = is_imm_s ? O0 : EXA;
          default:        nxt_s = O0;
        endcase
      end
      O0:   nxt_s = O1;
      O1: begin
        if (!adv_s) begin
          nxt_s = O1;
        end else begin
          case (op_class_s)
            CL_LD, CL_ST: nxt_s = A0;
            CL_MI:        nxt_s = EXI;
            default:      nxt_s = EXA;
          endcase
        end
      end
      EXA:  nxt_s = end_s;
      EXI:  nxt_s = end_s;
      MR0:  nxt_s = MR1;
      MR1:  nxt_s = end_s;
      A0:   nxt_s = (op_class_s == CL_ST) ? S1 : A1;
      A1:   nxt_s = adv_s ? A2 : A1;
      A2:   nxt_s = end_s;
      S1:   nxt_s = S2;
      S2:   nxt_s = adv_s ? end_s : S2;
      HALT: nxt_s = halt_req ? HALT : F0;
      default: nxt_s = IDLE;
    endcase
  end

  // Strobes and selects that belong to the state being entered
  always_comb begin
    strb_nxt_s   = '0;
    mode_nxt_s   = '0;
    select_nxt_s = '0;
    ram_in_nxt_s = RAM_IN_PC;
    case (nxt_s)
      F0, O0: strb_nxt_s.mar_we = 1'b1;
      F1, O1: begin
        strb_nxt_s.mbr_we = 1'b1;
        strb_nxt_s.pc_inc = 1'b1;
      end
      F2: strb_nxt_s.ir_we = 1'b1;
      EXA: begin
        strb_nxt_s.alu_mux  = 1'b1;
        strb_nxt_s.data_imm = is_imm_s;
        strb_nxt_s.acc_we   = (op_class_s != CL_CMP);
        strb_nxt_s.flag_we  = (op_class_s == CL_CMP);
        select_nxt_s        = rs_s;
        mode_nxt_s          = dec_mode_s;
      end
      EXI: begin
        strb_nxt_s.rf_we    = 1'b1;
        strb_nxt_s.data_imm = 1'b1;
        select_nxt_s        = rd_s;
      end
      MR0: begin
        strb_nxt_s.acc_we      = 1'b1;
        strb_nxt_s.alu_out_mux = 1'b1;
        select_nxt_s           = rs_s;
      end
      MR1: begin
        strb_nxt_s.rf_we  = 1'b1;
        strb_nxt_s.rf_mux = 1'b1;
        select_nxt_s      = rd_s;
      end
      A0: begin
        strb_nxt_s.mar_we = 1'b1;
        ram_in_nxt_s      = RAM_IN_MBR;
      end
      A1: strb_nxt_s.mbr_we = 1'b1;
      A2: begin
        strb_nxt_s.acc_we   = 1'b1;
        strb_nxt_s.data_imm = 1'b1;
        mode_nxt_s          = MODE_W'(MODE_PASS);
      end
      S1: begin
        strb_nxt_s.mbr_mux = 1'b1;
        strb_nxt_s.mbr_we  = 1'b1;
      end
      S2:   strb_nxt_s.ram_we = 1'b1;
      HALT: strb_nxt_s.halted = 1'b1;
      default: strb_nxt_s = '0;
    endcase
  end

  // State and output registers; reset clears every strobe at once
  always_ff @(posedge cu_clk or posedge cu_rst) begin
    if (cu_rst) begin
      state_r  <= IDLE;
      strb_r   <= '0;
      mode_r   <= '0;
      select_r <= '0;
      ram_in_r <= RAM_IN_PC;
    end else begin
      state_r  <= nxt_s;
      strb_r   <= strb_nxt_s;
      mode_r   <= mode_nxt_s;
      select_r <= select_nxt_s;
      ram_in_r <= ram_in_nxt_s;
    end
  end

  assign state       = state_r;
  assign mode        = mode_r;
  assign select      = select_r;
  assign ram_in      = ram_in_r;
  assign mbr_we      = strb_r.mbr_we & gate_s;
  assign pc_inc      = strb_r.pc_inc & gate_s;
  assign ram_we      = strb_r.ram_we & gate_s;
  assign ir_we       = strb_r.ir_we;
  assign rf_we       = strb_r.rf_we;
  assign acc_we      = strb_r.acc_we;
  assign mar_we      = strb_r.mar_we;
  assign alu_mux     = strb_r.alu_mux;
  assign rf_mux      = strb_r.rf_mux;
  assign alu_out_mux = strb_r.alu_out_mux;
  assign mbr_mux     = strb_r.mbr_mux;
  assign data_imm    = strb_r.data_imm;
  assign flag_we     = strb_r.flag_we;
  assign halted      = strb_r.halted;

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed testbench for cu_multicycle with hand-computed expectations.
// Build with CU_WAIT_EN defined to also exercise the mem_rdy wait.
module tb_cu_multicycle;

  logic       cu_clk = 1'b0;
  logic       cu_rst;
  logic [7:0] cu_in;
  logic       mem_rdy;
  logic       halt_req;
  logic [4:0] state;
  logic [2:0] mode;
  logic [1:0] select;
  logic [1:0] ram_in;
  logic mbr_we, ir_we, pc_inc, rf_we, acc_we, mar_we, ram_we;
  logic alu_mux, rf_mux, alu_out_mux, mbr_mux, data_imm, flag_we, halted;

  int n_chk  = 0;
  int n_fail = 0;

  // Strobe bit positions in the packed observation vector
  localparam logic [13:0] B_MBR = 14'h2000;
  localparam logic [13:0] B_IR  = 14'h1000;
  localparam logic [13:0] B_PC  = 14'h0800;
  localparam logic [13:0] B_RF  = 14'h0400;
  localparam logic [13:0] B_ACC = 14'h0200;
  localparam logic [13:0] B_MAR = 14'h0100;
  localparam logic [13:0] B_RAM = 14'h0080;
  localparam logic [13:0] B_ALU = 14'h0040;
  localparam logic [13:0] B_RFM = 14'h0020;
  localparam logic [13:0] B_AOM = 14'h0010;
  localparam logic [13:0] B_MBM = 14'h0008;
  localparam logic [13:0] B_IMM = 14'h0004;
  localparam logic [13:0] B_FLG = 14'h0002;
  localparam logic [13:0] B_HLT = 14'h0001;

  logic [13:0] strb_w;
  assign strb_w = {mbr_we, ir_we, pc_inc, rf_we, acc_we, mar_we, ram_we,
                   alu_mux, rf_mux, alu_out_mux, mbr_mux, data_imm, flag_we, halted};

  cu_multicycle #(.DW(8), .RSEL_W(2), .MODE_W(3)) dut (
    .cu_clk(cu_clk), .cu_rst(cu_rst), .cu_in(cu_in), .mem_rdy(mem_rdy),
    .halt_req(halt_req), .state(state), .mode(mode), .select(select),
    .ram_in(ram_in), .mbr_we(mbr_we), .ir_we(ir_we), .pc_inc(pc_inc),
    .rf_we(rf_we), .acc_we(acc_we), .mar_we(mar_we), .ram_we(ram_we),
    .alu_mux(alu_mux), .rf_mux(rf_mux), .alu_out_mux(alu_out_mux),
    .mbr_mux(mbr_mux), .data_imm(data_imm), .flag_we(flag_we), .halted(halted)
  );

  always #5 cu_clk = ~cu_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check every output of the current cycle, then move to the next one
  task automatic cycle_chk(input string tag, input logic [4:0] st, input logic [13:0] sb,
                           input logic [2:0] md, input logic [1:0] sl, input logic [1:0] ri);
    #1;
    chk({tag, ".state"},  {27'd0, state},  {27'd0, st});
    chk({tag, ".strb"},   {18'd0, strb_w}, {18'd0, sb});
    chk({tag, ".mode"},   {29'd0, mode},   {29'd0, md});
    chk({tag, ".select"}, {30'd0, select}, {30'd0, sl});
    chk({tag, ".ram_in"}, {30'd0, ram_in}, {30'd0, ri});
    @(negedge cu_clk);
  endtask

  task automatic fetch(input string tag);
    cycle_chk({tag, ".f0"},  5'd1, B_MAR,        3'd0, 2'd0, 2'd0);
    cycle_chk({tag, ".f1"},  5'd2, B_MBR | B_PC, 3'd0, 2'd0, 2'd0);
    cycle_chk({tag, ".f2"},  5'd3, B_IR,         3'd0, 2'd0, 2'd0);
    cycle_chk({tag, ".dec"}, 5'd4, 14'd0,        3'd0, 2'd0, 2'd0);
  endtask

  task automatic operand(input string tag);
    cycle_chk({tag, ".o0"}, 5'd5, B_MAR,        3'd0, 2'd0, 2'd0);
    cycle_chk({tag, ".o1"}, 5'd6, B_MBR | B_PC, 3'd0, 2'd0, 2'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    cu_rst   = 1'b1;
    cu_in    = 8'h00;
    mem_rdy  = 1'b1;
    halt_req = 1'b0;
    repeat (2) @(negedge cu_clk);
    cu_rst = 1'b0;
    cycle_chk("reset.idle", 5'd0, 14'd0, 3'd0, 2'd0, 2'd0);

    // SUM r1: 5 cycles, back at F0 afterwards
    cu_in = 8'h41;
    fetch("sum");
    cycle_chk("sum.exa", 5'd7, B_ALU | B_ACC, 3'b000, 2'b01, 2'd0);

    // SMI #imm
    cu_in = 8'hC0;
    fetch("smi");
    operand("smi");
    cycle_chk("smi.exa", 5'd7, B_ALU | B_ACC | B_IMM, 3'b000, 2'b00, 2'd0);

    // MR rd=01, rs=10
    cu_in = 8'h36;
    fetch("mr");
    cycle_chk("mr.mr0", 5'd9,  B_ACC | B_AOM, 3'd0, 2'b10, 2'd0);
    cycle_chk("mr.mr1", 5'd10, B_RF | B_RFM,  3'd0, 2'b01, 2'd0);

    // CMI: flag only, accumulator untouched
    cu_in = 8'hF0;
    fetch("cmi");
    operand("cmi");
    cycle_chk("cmi.exa", 5'd7, B_ALU | B_IMM | B_FLG, 3'b010, 2'b00, 2'd0);

    // XRR r2
    cu_in = 8'hA6;
    fetch("xrr");
    cycle_chk("xrr.exa", 5'd7, B_ALU | B_ACC, 3'b101, 2'b10, 2'd0);

    // ANR r3
    cu_in = 8'h63;
    fetch("anr");
    cycle_chk("anr.exa", 5'd7, B_ALU | B_ACC, 3'b011, 2'b11, 2'd0);

    // MI rd=11
    cu_in = 8'h2C;
    fetch("mi");
    operand("mi");
    cycle_chk("mi.exi", 5'd8, B_RF | B_IMM, 3'd0, 2'b11, 2'd0);

    // LD, then halt at the instruction boundary
    cu_in = 8'h00;
    fetch("ld");
    operand("ld");
`ifdef CU_WAIT_EN
    mem_rdy = 1'b0;
`endif
    cycle_chk("ld.a0", 5'd11, B_MAR, 3'd0, 2'd0, 2'b01);
`ifdef CU_WAIT_EN
    repeat (3) cycle_chk("ld.a1wait", 5'd12, 14'd0, 3'd0, 2'd0, 2'd0);
    mem_rdy = 1'b1;
`endif
    cycle_chk("ld.a1", 5'd12, B_MBR, 3'd0, 2'd0, 2'd0);
    halt_req = 1'b1;
    cycle_chk("ld.a2",  5'd13, B_ACC | B_IMM, 3'b110, 2'd0, 2'd0);
    cycle_chk("halt.0", 5'd16, B_HLT, 3'd0, 2'd0, 2'd0);
    cycle_chk("halt.1", 5'd16, B_HLT, 3'd0, 2'd0, 2'd0);
    halt_req = 1'b0;
    cycle_chk("halt.2", 5'd16, B_HLT, 3'd0, 2'd0, 2'd0);

    // ST, reset asserted while in S2
    cu_in = 8'h10;
    fetch("st");
    operand("st");
    cycle_chk("st.a0", 5'd11, B_MAR, 3'd0, 2'd0, 2'b01);
    cycle_chk("st.s1", 5'd14, B_MBM | B_MBR, 3'd0, 2'd0, 2'd0);
    #1;
    chk("st.s2.state", {27'd0, state}, 32'd15);
    chk("st.s2.ram_we", {31'd0, ram_we}, 32'd1);
    #2;
    cu_rst = 1'b1;
    #1;
    chk("rst.ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst.state", {27'd0, state}, 32'd0);
    chk("rst.strb", {18'd0, strb_w}, 32'd0);
    @(negedge cu_clk);
    cu_rst = 1'b0;
    cycle_chk("rst.idle", 5'd0, 14'd0, 3'd0, 2'd0, 2'd0);
    cycle_chk("rst.f0",   5'd1, B_MAR, 3'd0, 2'd0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
